// File: rtl/softmax_argmax_if.sv
// Handshake and result bundle between the softmax stage, the classifier and the host status port.
// The master drives the request; the slave drives busy/done and the registered results.
interface softmax_argmax_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NODES      = 8
);
    localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;

    logic                          start;
    logic [DATA_WIDTH*NODES-1:0]   probs;
    logic                          busy;
    logic                          done;
    logic [IDX_W-1:0]              class_idx;
    logic [DATA_WIDTH-1:0]         max_prob;
    logic [DATA_WIDTH-1:0]         second_prob;
    logic [DATA_WIDTH-1:0]         margin;
    logic                          confident;
    logic                          sum_err;

    modport master (
        output start, probs,
        input  busy, done, class_idx, max_prob, second_prob, margin, confident, sum_err
    );

    modport slave (
        input  start, probs,
        output busy, done, class_idx, max_prob, second_prob, margin, confident, sum_err
    );
endinterface

// File: rtl/softmax_argmax.sv
// Sequential top-2 / argmax scan over a latched Q0.8 probability vector, one element per cycle.
// Latency NODES+1 edges from accepted start to done; start is ignored while scanning.
module softmax_argmax #(
    parameter int DATA_WIDTH = 8,
    parameter int NODES      = 8,
    parameter int THRESH     = 128,
    parameter int MARGIN_MIN = 32,
    parameter int SUM_TOL    = 8
) (
    input  logic              clk,
    input  logic              reset,
    softmax_argmax_if.slave   bus
);
    localparam int IDX_W = $clog2(NODES);
    localparam int SUM_W = DATA_WIDTH + $clog2(NODES);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                      state;
    logic [DATA_WIDTH*NODES-1:0] vec;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            best_idx;
    logic [DATA_WIDTH-1:0]       best;
    logic [DATA_WIDTH-1:0]       second;
    logic [SUM_W-1:0]            sum;

    logic [DATA_WIDTH-1:0]       elem;
    logic [IDX_W-1:0]            nxt_best_idx;
    logic [DATA_WIDTH-1:0]       nxt_best;
    logic [DATA_WIDTH-1:0]       nxt_second;
    logic [DATA_WIDTH-1:0]       nxt_margin;
    logic [SUM_W-1:0]            nxt_sum;
    logic                        nxt_conf;
    logic                        nxt_sum_err;
    logic                        last;
    int                          sum_val;
    int                          sum_dev;

    always_comb begin
        elem         = vec[DATA_WIDTH*idx +: DATA_WIDTH];
        nxt_best     = best;
        nxt_second   = second;
        nxt_best_idx = best_idx;
        // Strict compares: the earliest index keeps the max, an equal later value lands in second.
        if (elem > best) begin
            nxt_second   = best;
            nxt_best     = elem;
            nxt_best_idx = idx;
        end else if (elem > second) begin
            nxt_second = elem;
        end
        nxt_sum     = sum + SUM_W'(elem);
        nxt_margin  = nxt_best - nxt_second;
        nxt_conf    = (nxt_best >= DATA_WIDTH'(THRESH)) && (nxt_margin >= DATA_WIDTH'(MARGIN_MIN));
        sum_val     = int'(nxt_sum);
        sum_dev     = (sum_val > 256) ? (sum_val - 256) : (256 - sum_val);
        nxt_sum_err = (sum_dev > SUM_TOL);
        last        = (idx == IDX_W'(NODES - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            vec             <= '0;
            idx             <= '0;
            best_idx        <= '0;
            best            <= '0;
            second          <= '0;
            sum             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.class_idx   <= '0;
            bus.max_prob    <= '0;
            bus.second_prob <= '0;
            bus.margin      <= '0;
            bus.confident   <= 1'b0;
            bus.sum_err     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        vec      <= bus.probs;
                        idx      <= '0;
                        best_idx <= '0;
                        best     <= '0;
                        second   <= '0;
                        sum      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    best     <= nxt_best;
                    second   <= nxt_second;
                    best_idx <= nxt_best_idx;
                    sum      <= nxt_sum;
                    idx      <= idx + 1'b1;
                    // All results commit together so the host never sees a mixed set.
                    if (last) begin
                        bus.class_idx   <= nxt_best_idx;
                        bus.max_prob    <= nxt_best;
                        bus.second_prob <= nxt_second;
                        bus.margin      <= nxt_margin;
                        bus.confident   <= nxt_conf;
                        bus.sum_err     <= nxt_sum_err;
                        bus.done        <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_argmax.sv
// Randomised and directed bench for softmax_argmax against a sort-based reference model.
module tb_softmax_argmax;
    localparam int DW = 8;
    localparam int N  = 8;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] mx;
        logic [7:0] sec;
        logic [7:0] mar;
        logic       conf;
        logic       serr;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    res_t last_res;

    always #5 clk = ~clk;

    softmax_argmax_if #(.DATA_WIDTH(DW), .NODES(N)) bus ();

    softmax_argmax #(
        .DATA_WIDTH(DW), .NODES(N), .THRESH(128), .MARGIN_MIN(32), .SUM_TOL(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic res_t obs();
        return '{bus.class_idx, bus.max_prob, bus.second_prob, bus.margin, bus.confident, bus.sum_err};
    endfunction

    // Reference: sort for the max, first occurrence for the index, sort the rest for second.
    function automatic res_t model(input logic [63:0] p);
        int   v[N];
        int   all[$];
        int   rest[$];
        int   mx, mi, sec, sum;
        res_t r;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            v[i] = int'(p[8*i +: 8]);
            all.push_back(v[i]);
            sum += v[i];
        end
        all.rsort();
        mx = all[0];
        mi = -1;
        for (int i = 0; i < N; i++) if (mi < 0 && v[i] == mx) mi = i;
        for (int i = 0; i < N; i++) if (i != mi) rest.push_back(v[i]);
        rest.rsort();
        sec    = rest[0];
        r.idx  = 3'(mi);
        r.mx   = 8'(mx);
        r.sec  = 8'(sec);
        r.mar  = 8'(mx - sec);
        r.conf = (mx >= 128) && ((mx - sec) >= 32);
        r.serr = (sum > 256 + 8) || (sum < 256 - 8);
        return r;
    endfunction

    // Issues one request from idle; reports edges to done, results, pre-done results, busy and done width.
    task automatic run_vec(input logic [63:0] p, output int lat, output res_t got, output res_t pre,
                           output logic busy_bad, output logic done_next);
        res_t prev;
        lat       = -1;
        got       = '0;
        busy_bad  = 1'b0;
        bus.probs = p;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.probs = 64'($urandom()) ^ {32'($urandom()), 32'h0};
        prev = obs();
        pre  = prev;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                got = obs();
                pre = prev;
                if (bus.busy) busy_bad = 1'b1;
                break;
            end
            if (!bus.busy) busy_bad = 1'b1;
            prev = obs();
        end
        @(posedge clk);
        #1 done_next = bus.done;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.probs = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== res_t'(0) || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got res=%h busy=%b done=%b exp all 0", obs(), bus.busy, bus.done);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        last_res = '0;
    endtask

    task automatic test_directed();
        int   tbl[5][8] = '{'{0,0,1,3,8,21,59,161}, '{40,40,40,40,32,32,16,16},
                            '{0,200,0,0,0,0,0,0}, '{100,120,0,0,0,0,0,36}, '{0,0,0,0,0,0,0,0}};
        res_t exp_r[5]  = '{'{3'd7, 8'd161, 8'd59, 8'd102, 1'b1, 1'b0},
                            '{3'd0, 8'd40, 8'd40, 8'd0, 1'b0, 1'b0},
                            '{3'd1, 8'd200, 8'd0, 8'd200, 1'b1, 1'b1},
                            '{3'd1, 8'd120, 8'd100, 8'd20, 1'b0, 1'b0},
                            '{3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1}};
        logic [63:0] p;
        int lat;
        res_t got, pre;
        logic bb, dn;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) p[8*i +: 8] = 8'(tbl[k][i]);
            run_vec(p, lat, got, pre, bb, dn);
            checks++;
            if (lat + 1 !== N + 1) begin
                failures++;
                $display("FAIL dir%0d_latency got=%0d edges exp=%0d", k, lat + 1, N + 1);
            end
            checks++;
            if (got !== exp_r[k]) begin
                failures++;
                $display("FAIL dir%0d_result got=%h exp=%h", k, got, exp_r[k]);
            end
            checks++;
            if (pre !== last_res) begin
                failures++;
                $display("FAIL dir%0d_hold got=%h exp=%h", k, pre, last_res);
            end
            checks++;
            if (bb !== 1'b0 || dn !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_busy_done got=%b%b exp=00", k, bb, dn);
            end
            last_res = exp_r[k];
        end
    endtask

    task automatic test_random();
        logic [63:0] p;
        int   lat, mode;
        res_t got, pre, exp_r;
        logic bb, dn;
        for (int k = 0; k < 30; k++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0:       p[8*i +: 8] = 8'($urandom_range(0, 255));
                    1:       p[8*i +: 8] = 8'($urandom_range(0, 63));
                    default: p[8*i +: 8] = 8'(64 * $urandom_range(0, 2));
                endcase
            end
            exp_r = model(p);
            run_vec(p, lat, got, pre, bb, dn);
            checks++;
            if (lat !== N) begin
                failures++;
                $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, lat, N);
            end
            checks++;
            if (got !== exp_r) begin
                failures++;
                $display("FAIL rnd%0d_result vec=%h got=%h exp=%h", k, p, got, exp_r);
            end
            checks++;
            if (pre !== last_res) begin
                failures++;
                $display("FAIL rnd%0d_hold got=%h exp=%h", k, pre, last_res);
            end
            checks++;
            if (bb !== 1'b0 || dn !== 1'b0) begin
                failures++;
                $display("FAIL rnd%0d_busy_done got=%b%b exp=00", k, bb, dn);
            end
            last_res = exp_r;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] v[6];
        int n;
        logic seen;
        for (int k = 0; k < 6; k++) v[k] = {32'($urandom()), 32'($urandom())};
        bus.probs = v[0];
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.probs = v[1];
        for (int r = 0; r < 4; r++) begin
            n = 0;
            for (int t = 1; t <= 40; t++) begin
                @(posedge clk);
                #1;
                n = t;
                if (r > 0 && t == 1) bus.probs = v[r + 1];
                if (t == 4) bus.probs = ~v[r + 1];
                if (t == 6) bus.probs = v[r + 1];
                if (bus.done) break;
            end
            if (r == 3) bus.start = 1'b0;
            checks++;
            if (n !== ((r == 0) ? N : N + 1)) begin
                failures++;
                $display("FAIL b2b%0d_spacing got=%0d exp=%0d", r, n, (r == 0) ? N : N + 1);
            end
            checks++;
            if (obs() !== model(v[r])) begin
                failures++;
                $display("FAIL b2b%0d_result got=%h exp=%h", r, obs(), model(v[r]));
            end
        end
        seen = 1'b0;
        repeat (N + 3) begin
            @(posedge clk);
            #1 if (bus.done || bus.busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_after got=%b exp=0", seen);
        end
        last_res = model(v[3]);
    endtask

    task automatic test_midrun_reset();
        logic [63:0] p;
        int   lat;
        res_t got, pre, exp_r;
        logic bb, dn, seen;
        bus.probs = 64'hA1_3B_15_08_03_01_00_00;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (obs() !== res_t'(0) || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear got res=%h busy=%b done=%b exp all 0", obs(), bus.busy, bus.done);
        end
        seen = 1'b0;
        repeat (N + 2) begin
            @(posedge clk);
            #1 if (bus.done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_done got=%b exp=0", seen);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) p[8*i +: 8] = 8'($urandom_range(0, 80));
        exp_r = model(p);
        run_vec(p, lat, got, pre, bb, dn);
        checks++;
        if (lat !== N) begin
            failures++;
            $display("FAIL midrst_latency got=%0d exp=%0d", lat, N);
        end
        checks++;
        if (got !== exp_r) begin
            failures++;
            $display("FAIL midrst_result got=%h exp=%h", got, exp_r);
        end
        checks++;
        if (pre !== res_t'(0)) begin
            failures++;
            $display("FAIL midrst_hold got=%h exp=0", pre);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/softmax_argmax.md
Name: softmax_argmax

Overview:
- Classifier stage directly downstream of softmax8.
- Consumes the packed Q0.8 probability vector that softmax8 produces when its done asserts.
- Sequentially scans the vector and reports the winning class index, the top-2 probabilities and their margin, a confidence flag, and a normalisation sanity flag.
- Final stage of the MLP inference path; results go to the host/status interface.

Parameters:
- DATA_WIDTH, 8, width of one probability element (unsigned Q0.8).
- NODES, 8, number of classes; must be at least 2.
- THRESH, 128, minimum max_prob for confident (128 = 0.5).
- MARGIN_MIN, 32, minimum (max_prob - second_prob) for confident.
- SUM_TOL, 8, allowed |sum - 256| before sum_err is raised.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; driven from softmax8 done.
- probs  input  DATA_WIDTH*NODES  packed probabilities; element i = probs[DATA_WIDTH*i +: DATA_WIDTH].
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when results update.
- class_idx  output  $clog2(NODES)  index of the maximum element.
- max_prob  output  DATA_WIDTH  maximum element value.
- second_prob  output  DATA_WIDTH  second-largest element value.
- margin  output  DATA_WIDTH  max_prob - second_prob.
- confident  output  1  (max_prob >= THRESH) && (margin >= MARGIN_MIN).
- sum_err  output  1  |sum of elements - 256| > SUM_TOL.

Behaviour:
- Reset asserted (low): state IDLE and all outputs 0, including busy, done and every result. Asynchronous, so it also aborts a scan in progress; no done is produced for the aborted request.
- FSM states: IDLE, SCAN, DONE.
- IDLE, start=1 at the edge:
  - latch probs into an internal register;
  - set scan index = 0; clear best, second and sum accumulators;
  - go to SCAN; busy=1 from the next cycle.
- SCAN, one element per edge; element e = latched[idx]:
  - if e > best: second <= best, best <= e, best_idx <= idx;
  - else if e > second: second <= e;
  - sum += e;
  - idx++.
- Ties: strict comparison, so the lowest index wins the max. An equal value becomes second (second = best, margin = 0).
- On the edge that processes idx = NODES-1, all results register at once:
  - class_idx, max_prob, second_prob, margin, confident, sum_err;
  - state goes to DONE; done=1 and busy=0 in the following cycle.
- Latency: start sampled at edge k; done high for exactly the cycle after edge k+NODES (NODES+1 edges total; 9 for NODES=8).
- DONE lasts one cycle and then goes to IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, one request per NODES+1 cycles).
- start during SCAN is ignored; the latched probs are unaffected by input changes.
- Result outputs hold their values until the next done. They are never partially updated.
- Arithmetic:
  - sum accumulator width DATA_WIDTH+$clog2(NODES), cannot overflow;
  - margin is unsigned and non-negative by construction;
  - sum_err compares against 256 using signed or absolute difference, no wrap.
- All-zero vector: class_idx=0, max=second=0, margin=0, confident=0, sum_err=1.

Test Plan:
- Reset low mid-run, 3 cycles after start -> all outputs 0 immediately; no done pulse; a fresh start after release completes normally in 9 cycles.
- probs elements 0..7 = {0,0,1,3,8,21,59,161}, one start -> done exactly 9 edges after start; class_idx=7, max=161, second=59, margin=102, confident=1, sum_err=0 (sum 253).
- Elements {40,40,40,40,32,32,16,16} -> class_idx=0, max=40, second=40, margin=0, confident=0, sum_err=0 (sum 256).
- Elements {0,200,0,0,0,0,0,0} -> class_idx=1, max=200, second=0, margin=200, confident=1, sum_err=1 (sum 200).
- start held high continuously with the vector swapped between requests -> each done separated by 9 cycles; start pulses during SCAN ignored; results match the vector latched at each accepted start.
- Elements {100,120,0,0,0,0,0,36} -> class_idx=1, second=100, margin=20 < 32 -> confident=0, sum_err=0.
